demux_stream_ctrl: RTL

Upstream feeder for the 1:4 demultiplexer stage. Accepts a serial framed bit stream over a valid/ready handshake, decodes a 2-bit destination, and drives the demux data bit and select. Checks even parity per frame, keeps per-channel good-frame counters, and aborts stalled frames on timeout.

---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_frame_counters.sv | 30 +++
 rtl/demux_stream_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the framed-stream demux feeder.
package demux_stream_pkg;

  localparam int unsigned ADDR_BITS = 2;
  localparam int unsigned NUM_CH    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PAR,
    DONE
  } state_e;

endpackage

// File: rtl/demux_frame_counters.sv
// Per-channel saturating good-frame counters with a combinational read port.
module demux_frame_counters
  import demux_stream_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic [ADDR_BITS-1:0] inc_sel,
  input  logic [ADDR_BITS-1:0] cnt_rd_sel,
  output logic [CNT_W-1:0]     cnt_rd_data
);

  logic [CNT_W-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc && (cnt_q[inc_sel] != '1)) begin
      cnt_q[inc_sel] <= cnt_q[inc_sel] + CNT_W'(1);
    end
  end

  // Read sees the pre-increment value during the incrementing cycle.
  assign cnt_rd_data = cnt_q[cnt_rd_sel];

endmodule

// File: rtl/demux_stream_ctrl.sv
// Framed serial stream decoder feeding a 1:4 demux: address decode, even parity,
// stall timeout and per-channel good-frame counting.
module demux_stream_ctrl
  import demux_stream_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 demux_in,
  output logic [ADDR_BITS-1:0] select,
  output logic                 bit_valid,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 frame_abort,
  input  logic [ADDR_BITS-1:0] cnt_rd_sel,
  output logic [CNT_W-1:0]     cnt_rd_data
);

  localparam int unsigned BCNT_W  = $clog2(DATA_LEN + 1);
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam int unsigned ACNT_W  = $clog2(ADDR_BITS);

  localparam logic [BCNT_W-1:0]  LAST_BIT   = BCNT_W'(DATA_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [ACNT_W-1:0]  LAST_ADDR  = ACNT_W'(ADDR_BITS - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [ACNT_W-1:0]      acnt_q, acnt_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic                   par_q, par_d;
  logic [ADDR_BITS-1:0]   select_q, select_d;
  logic                   demux_q, demux_d;
  logic                   bit_valid_q, bit_valid_d;
  logic                   done_q, done_d;
  logic                   perr_q, perr_d;
  logic                   abort_q, abort_d;
  logic                   accept;
  logic                   inc_c;

  // Ready is a decode of the state register, forced low while reset is held.
  assign in_ready = ~reset & (state_q != DONE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      acnt_q      <= '0;
      bcnt_q      <= '0;
      stall_q     <= '0;
      par_q       <= 1'b0;
      select_q    <= '0;
      demux_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      acnt_q      <= acnt_d;
      bcnt_q      <= bcnt_d;
      stall_q     <= stall_d;
      par_q       <= par_d;
      select_q    <= select_d;
      demux_q     <= demux_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    acnt_d      = acnt_q;
    bcnt_d      = bcnt_q;
    stall_d     = stall_q;
    par_d       = par_q;
    select_d    = select_q;
    demux_d     = 1'b0;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    perr_d      = 1'b0;
    abort_d     = 1'b0;
    inc_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && in_bit) begin
          state_d = ADDR;
          acnt_d  = '0;
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d = {addr_q[ADDR_BITS-2:0], in_bit};
          acnt_d = acnt_q + ACNT_W'(1);
          if (acnt_q == LAST_ADDR) begin
            select_d = {addr_q[ADDR_BITS-2:0], in_bit};
            bcnt_d   = '0;
            par_d    = 1'b0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          par_d       = par_q ^ in_bit;
          demux_d     = in_bit;
          bit_valid_d = 1'b1;
          if (bcnt_q == LAST_BIT) begin
            state_d = PAR;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      PAR: begin
        if (accept) begin
          done_d  = 1'b1;
          perr_d  = par_q ^ in_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        inc_c   = ~perr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stall watchdog only runs while a frame is in flight.
    if (state_q inside {ADDR, DATA, PAR}) begin
      if (accept) begin
        stall_d = '0;
      end else if (!in_valid) begin
        if (stall_q == STALL_LAST) begin
          stall_d = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    end else begin
      stall_d = '0;
    end
  end

  assign demux_in    = demux_q;
  assign bit_valid   = bit_valid_q;
  assign select      = select_q;
  assign frame_done  = done_q;
  assign parity_err  = perr_q;
  assign frame_abort = abort_q;

  demux_frame_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk         (clk),
    .reset       (reset),
    .inc         (inc_c),
    .inc_sel     (select_q),
    .cnt_rd_sel  (cnt_rd_sel),
    .cnt_rd_data (cnt_rd_data)
  );

endmodule
